// File: rtl/fml_16_bit_splitter_pkg.sv
// Shared definitions for the 32-to-16-bit FML splitter.
// Contents: state encoding, half-select constants, and the beat
// byte-enable helper used by the splitter datapath.
package fml16_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BEAT_H = 2'd1,
        BEAT_L = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic HALF_HI = 1'b0;
    localparam logic HALF_LO = 1'b1;

    // Reads always fetch a full halfword; writes use the selected half of sel.
    function automatic logic [1:0] beat_be(input logic we, input logic half,
                                           input logic [3:0] sel);
        if (!we)
            return 2'b11;
        else if (half == HALF_HI)
            return sel[3:2];
        else
            return sel[1:0];
    endfunction

endpackage

// File: rtl/fml_16_bit_splitter_if.sv
// Bus interfaces for the FML splitter.
// fml32_if : 32-bit FML single-word port (upstream is master).
//   fml_adr/fml_stb/fml_we/fml_sel/fml_di : master -> slave
//   fml_do/fml_ack                        : slave  -> master
// mem16_if : 16-bit memory/PHY beat port (splitter is master).
//   mem_req/mem_we/mem_adr/mem_be/mem_wdat : master -> slave
//   mem_rdat/mem_ack                       : slave  -> master
interface fml32_if #(
    parameter int ADDR_W = 26
);
    logic [ADDR_W-1:0] fml_adr;
    logic              fml_stb;
    logic              fml_we;
    logic [3:0]        fml_sel;
    logic [31:0]       fml_di;
    logic [31:0]       fml_do;
    logic              fml_ack;

    modport master (
        output fml_adr, fml_stb, fml_we, fml_sel, fml_di,
        input  fml_do, fml_ack
    );

    modport slave (
        input  fml_adr, fml_stb, fml_we, fml_sel, fml_di,
        output fml_do, fml_ack
    );
endinterface

interface mem16_if #(
    parameter int HW_ADDR_W = 25
);
    logic                 mem_req;
    logic                 mem_we;
    logic [HW_ADDR_W-1:0] mem_adr;
    logic [1:0]           mem_be;
    logic [15:0]          mem_wdat;
    logic [15:0]          mem_rdat;
    logic                 mem_ack;

    modport master (
        output mem_req, mem_we, mem_adr, mem_be, mem_wdat,
        input  mem_rdat, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_adr, mem_be, mem_wdat,
        output mem_rdat, mem_ack
    );
endinterface

// File: rtl/fml_16_bit_splitter.sv
// Splits one 32-bit FML single-word transaction into two 16-bit memory
// beats (upper half first), reassembles read data and returns a one-cycle
// FML ack.
// Ports:
//   sys_clk   : system clock
//   sys_rst_n : asynchronous active-low reset
//   fml       : 32-bit FML slave port (fml32_if.slave)
//   mem       : 16-bit memory master port (mem16_if.master)
module fml_16_bit_splitter
    import fml16_pkg::*;
#(
    parameter int ADDR_W    = 26,
    parameter int HW_ADDR_W = ADDR_W - 1
) (
    input  logic     sys_clk,
    input  logic     sys_rst_n,
    fml32_if.slave   fml,
    mem16_if.master  mem
);

    state_t state_q, state_d;

    logic [ADDR_W-3:0] adr_q, adr_d;
    logic              we_q, we_d;
    logic [3:0]        sel_q, sel_d;
    logic [31:0]       di_q, di_d;
    logic [15:0]       rd_hi, rd_lo;

    logic                 req_d, mem_we_d, ack_d, half_d;
    logic [HW_ADDR_W-1:0] mem_adr_d;
    logic [1:0]           mem_be_d;
    logic [15:0]          mem_wdat_d;

    // Byte-address bits [1:0] are not needed on a word-wide FML request.
    logic unused_adr_lsb;
    assign unused_adr_lsb = ^fml.fml_adr[1:0];

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        we_d    = we_q;
        sel_d   = sel_q;
        di_d    = di_q;

        case (state_q)
            IDLE: begin
                if (fml.fml_stb) begin
                    adr_d = fml.fml_adr[ADDR_W-1:2];
                    we_d  = fml.fml_we;
                    sel_d = fml.fml_sel;
                    di_d  = fml.fml_di;
                    if (fml.fml_we && fml.fml_sel == 4'b0000)
                        state_d = DONE;
                    else if (fml.fml_we && fml.fml_sel[3:2] == 2'b00)
                        state_d = BEAT_L;
                    else
                        state_d = BEAT_H;
                end
            end
            BEAT_H: begin
                if (mem.mem_ack) begin
                    if (we_q && sel_q[1:0] == 2'b00)
                        state_d = DONE;
                    else
                        state_d = BEAT_L;
                end
            end
            BEAT_L: begin
                if (mem.mem_ack)
                    state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state and next capture values, then
    // registered, so they line up with the state register cycle for cycle.
    always_comb begin
        req_d      = (state_d == BEAT_H) || (state_d == BEAT_L);
        half_d     = (state_d == BEAT_L) ? HALF_LO : HALF_HI;
        ack_d      = (state_d == DONE);
        mem_we_d   = 1'b0;
        mem_adr_d  = '0;
        mem_be_d   = '0;
        mem_wdat_d = '0;
        if (req_d) begin
            mem_we_d   = we_d;
            mem_adr_d  = {adr_d, half_d};
            mem_be_d   = beat_be(we_d, half_d, sel_d);
            mem_wdat_d = (half_d == HALF_HI) ? di_d[31:16] : di_d[15:0];
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= IDLE;
            adr_q        <= '0;
            we_q         <= 1'b0;
            sel_q        <= '0;
            di_q         <= '0;
            rd_hi        <= '0;
            rd_lo        <= '0;
            mem.mem_req  <= 1'b0;
            mem.mem_we   <= 1'b0;
            mem.mem_adr  <= '0;
            mem.mem_be   <= '0;
            mem.mem_wdat <= '0;
            fml.fml_ack  <= 1'b0;
        end else begin
            state_q      <= state_d;
            adr_q        <= adr_d;
            we_q         <= we_d;
            sel_q        <= sel_d;
            di_q         <= di_d;
            if (state_q == BEAT_H && mem.mem_ack && !we_q)
                rd_hi <= mem.mem_rdat;
            if (state_q == BEAT_L && mem.mem_ack && !we_q)
                rd_lo <= mem.mem_rdat;
            mem.mem_req  <= req_d;
            mem.mem_we   <= mem_we_d;
            mem.mem_adr  <= mem_adr_d;
            mem.mem_be   <= mem_be_d;
            mem.mem_wdat <= mem_wdat_d;
            fml.fml_ack  <= ack_d;
        end
    end

    assign fml.fml_do = {rd_hi, rd_lo};

endmodule

// File: tb/tb_fml_16_bit_splitter.sv
// Self-checking bench for fml_16_bit_splitter: table of directed
// transactions plus hand-written reset and spurious-ack sequences.
module tb_fml_16_bit_splitter;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    always #5 sys_clk = ~sys_clk;

    fml32_if #(.ADDR_W(26))    fml_bus ();
    mem16_if #(.HW_ADDR_W(25)) mem_bus ();

    fml_16_bit_splitter #(.ADDR_W(26)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .fml       (fml_bus),
        .mem       (mem_bus)
    );

    typedef struct {
        logic        we;
        logic [25:0] adr;
        logic [3:0]  sel;
        logic [31:0] di;
        logic [15:0] rd_h;
        logic [15:0] rd_l;
        int          nbeats;
        int          waits;
        logic        perturb;
        logic [24:0] a0;
        logic [1:0]  be0;
        logic [15:0] wd0;
        logic [24:0] a1;
        logic [1:0]  be1;
        logic [15:0] wd1;
    } vec_t;

    vec_t        vecs [9];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] last_do = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},  {31'd0, mem_bus.mem_req}, 32'd0);
        chk({tag, "_we"},   {31'd0, mem_bus.mem_we}, 32'd0);
        chk({tag, "_adr"},  {7'd0, mem_bus.mem_adr}, 32'd0);
        chk({tag, "_be"},   {30'd0, mem_bus.mem_be}, 32'd0);
        chk({tag, "_wdat"}, {16'd0, mem_bus.mem_wdat}, 32'd0);
        chk({tag, "_ack"},  {31'd0, fml_bus.fml_ack}, 32'd0);
        chk({tag, "_do"},   fml_bus.fml_do, 32'd0);
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int   beats;
        int   wcnt;
        int   lat;
        int   exp_lat;
        v     = vecs[idx];
        beats = 0;
        wcnt  = 0;
        lat   = -1;
        fml_bus.fml_adr = v.adr;
        fml_bus.fml_we  = v.we;
        fml_bus.fml_sel = v.sel;
        fml_bus.fml_di  = v.di;
        fml_bus.fml_stb = 1'b1;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            tick();
            mem_bus.mem_ack = 1'b0;
            if (v.perturb && cyc == 1) begin
                fml_bus.fml_adr = ~v.adr;
                fml_bus.fml_we  = ~v.we;
                fml_bus.fml_sel = ~v.sel;
                fml_bus.fml_di  = ~v.di;
            end
            if (fml_bus.fml_ack) begin
                lat = cyc;
                break;
            end
            if (!v.we && beats == 1)
                chk($sformatf("v%0d_do_partial", idx), fml_bus.fml_do, {v.rd_h, last_do[15:0]});
            else
                chk($sformatf("v%0d_do_hold", idx), fml_bus.fml_do, last_do);
            if (mem_bus.mem_req) begin
                if (wcnt == v.waits) begin
                    if (beats >= v.nbeats) begin
                        chk($sformatf("v%0d_extra_beat", idx), beats + 1, v.nbeats);
                    end else begin
                        chk($sformatf("v%0d_b%0d_adr", idx, beats), {7'd0, mem_bus.mem_adr},
                            {7'd0, (beats == 0) ? v.a0 : v.a1});
                        chk($sformatf("v%0d_b%0d_be", idx, beats), {30'd0, mem_bus.mem_be},
                            {30'd0, (beats == 0) ? v.be0 : v.be1});
                        chk($sformatf("v%0d_b%0d_we", idx, beats), {31'd0, mem_bus.mem_we},
                            {31'd0, v.we});
                        if (v.we)
                            chk($sformatf("v%0d_b%0d_wdat", idx, beats), {16'd0, mem_bus.mem_wdat},
                                {16'd0, (beats == 0) ? v.wd0 : v.wd1});
                    end
                    mem_bus.mem_ack  = 1'b1;
                    mem_bus.mem_rdat = (beats == 0) ? v.rd_h : v.rd_l;
                    beats++;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end
        end
        exp_lat = v.nbeats * (v.waits + 1) + 1;
        chk($sformatf("v%0d_ack_latency", idx), lat, exp_lat);
        chk($sformatf("v%0d_beats", idx), beats, v.nbeats);
        if (!v.we)
            last_do = {v.rd_h, v.rd_l};
        chk($sformatf("v%0d_do_done", idx), fml_bus.fml_do, last_do);
        fml_bus.fml_stb = 1'b0;
        mem_bus.mem_ack = 1'b0;
        tick();
        chk($sformatf("v%0d_ack_pulse", idx), {31'd0, fml_bus.fml_ack}, 32'd0);
        chk($sformatf("v%0d_req_idle", idx), {31'd0, mem_bus.mem_req}, 32'd0);
    endtask

    initial begin
        //          we  adr           sel      di            rd_h     rd_l    nb wt pt  a0          be0    wd0       a1          be1    wd1
        vecs[0] = '{1'b0, 26'h0000100, 4'b0001, 32'h0,        16'hDEAD, 16'hBEEF, 2, 0, 1'b0, 25'h0000080, 2'b11, 16'h0,    25'h0000081, 2'b11, 16'h0};
        vecs[1] = '{1'b1, 26'h0000200, 4'b1111, 32'h12345678, 16'h0,    16'h0,    2, 3, 1'b0, 25'h0000100, 2'b11, 16'h1234, 25'h0000101, 2'b11, 16'h5678};
        vecs[2] = '{1'b1, 26'h0000304, 4'b0011, 32'hCAFEF00D, 16'h0,    16'h0,    1, 0, 1'b0, 25'h0000183, 2'b11, 16'hF00D, 25'h0,       2'b00, 16'h0};
        vecs[3] = '{1'b1, 26'h0000308, 4'b1100, 32'hA5A55A5A, 16'h0,    16'h0,    1, 0, 1'b0, 25'h0000184, 2'b11, 16'hA5A5, 25'h0,       2'b00, 16'h0};
        vecs[4] = '{1'b1, 26'h0000400, 4'b0000, 32'hFFFFFFFF, 16'h0,    16'h0,    0, 0, 1'b0, 25'h0,       2'b00, 16'h0,    25'h0,       2'b00, 16'h0};
        vecs[5] = '{1'b1, 26'h3FFFFFC, 4'b1001, 32'h87654321, 16'h0,    16'h0,    2, 1, 1'b1, 25'h1FFFFFE, 2'b10, 16'h8765, 25'h1FFFFFF, 2'b01, 16'h4321};
        vecs[6] = '{1'b0, 26'h0001237, 4'b0000, 32'h0,        16'h1357, 16'h2468, 2, 2, 1'b1, 25'h000091A, 2'b11, 16'h0,    25'h000091B, 2'b11, 16'h0};
        vecs[7] = '{1'b0, 26'h0000010, 4'b1111, 32'h0,        16'hAAAA, 16'h5555, 2, 0, 1'b0, 25'h0000008, 2'b11, 16'h0,    25'h0000009, 2'b11, 16'h0};
        vecs[8] = '{1'b0, 26'h0000014, 4'b1111, 32'h0,        16'h0F0F, 16'hF0F0, 2, 2, 1'b0, 25'h000000A, 2'b11, 16'h0,    25'h000000B, 2'b11, 16'h0};

        fml_bus.fml_adr  = '0;
        fml_bus.fml_stb  = 1'b0;
        fml_bus.fml_we   = 1'b0;
        fml_bus.fml_sel  = '0;
        fml_bus.fml_di   = '0;
        mem_bus.mem_rdat = '0;
        mem_bus.mem_ack  = 1'b0;

        repeat (3) tick();
        chk_all_zero("reset");
        sys_rst_n = 1'b1;
        tick();

        for (int i = 0; i <= 6; i++)
            run_vec(i);

        // Reset asserted mid-transaction, while beat L is waiting.
        fml_bus.fml_adr = 26'h0000020;
        fml_bus.fml_we  = 1'b0;
        fml_bus.fml_sel = 4'b1111;
        fml_bus.fml_stb = 1'b1;
        tick();
        chk("rst_beat_h_req", {31'd0, mem_bus.mem_req}, 32'd1);
        chk("rst_beat_h_adr", {7'd0, mem_bus.mem_adr}, 32'h10);
        mem_bus.mem_ack  = 1'b1;
        mem_bus.mem_rdat = 16'h1111;
        tick();
        mem_bus.mem_ack = 1'b0;
        chk("rst_beat_l_adr", {7'd0, mem_bus.mem_adr}, 32'h11);
        chk("rst_beat_l_do", fml_bus.fml_do, {16'h1111, last_do[15:0]});
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk_all_zero("rst_async");
        fml_bus.fml_stb = 1'b0;
        tick();
        tick();
        sys_rst_n = 1'b1;
        last_do   = '0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("rst_after_ack_c%0d", c), {31'd0, fml_bus.fml_ack}, 32'd0);
            chk($sformatf("rst_after_req_c%0d", c), {31'd0, mem_bus.mem_req}, 32'd0);
        end

        // Back-to-back reads.
        run_vec(7);
        run_vec(8);

        // Spurious memory ack while idle.
        mem_bus.mem_ack  = 1'b1;
        mem_bus.mem_rdat = 16'hFFFF;
        tick();
        mem_bus.mem_ack = 1'b0;
        chk("spur_req", {31'd0, mem_bus.mem_req}, 32'd0);
        chk("spur_ack", {31'd0, fml_bus.fml_ack}, 32'd0);
        tick();
        chk("spur_req2", {31'd0, mem_bus.mem_req}, 32'd0);
        chk("spur_do", fml_bus.fml_do, 32'h0F0FF0F0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fml_16_bit_splitter.md
Name: fml_16_bit_splitter

Overview:
- Sits directly downstream of the 16-bit FML interface stage, between its DDR-side FML port and a 16-bit-wide memory/PHY port.
- Takes one 32-bit FML single-word transaction and performs it as two 16-bit beats: upper half first, then lower half.
- Reassembles read data into a 32-bit word and returns a single-cycle FML ack.

Parameters:
- ADDR_W, 26, FML byte-address width (matches SDRAM_DEPTH).
- HW_ADDR_W, ADDR_W-1, halfword address width on the memory side.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- fml_adr  in  ADDR_W  byte address; bits [1:0] ignored.
- fml_stb  in  1  request strobe, held until ack.
- fml_we  in  1  1=write, 0=read.
- fml_sel  in  4  byte enables; [3:2]=upper half, [1:0]=lower half.
- fml_di  in  32  write data from upstream.
- fml_do  out  32  read data to upstream.
- fml_ack  out  1  one-cycle completion pulse.
- mem_req  out  1  beat request, held until mem_ack.
- mem_we  out  1  beat direction.
- mem_adr  out  HW_ADDR_W  halfword address.
- mem_be  out  2  beat byte enables.
- mem_wdat  out  16  beat write data.
- mem_rdat  in  16  beat read data, valid with mem_ack.
- mem_ack  in  1  one-cycle per-beat acknowledge.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset (asserted at any time, including mid-transaction): state=IDLE; all outputs 0; capture registers 0. An interrupted transaction is abandoned with no ack.
- All outputs are registered.
- Capture: on acceptance in IDLE (fml_stb=1), latch fml_adr[ADDR_W-1:2], fml_we, fml_sel, fml_di. Later changes on fml_* are ignored until the next acceptance.
- Beat mapping:
  - Beat H: mem_adr={adr[ADDR_W-1:2],1'b0}, mem_be=sel[3:2], mem_wdat=di[31:16].
  - Beat L: mem_adr={adr[ADDR_W-1:2],1'b1}, mem_be=sel[1:0], mem_wdat=di[15:0].
- State machine:
  - IDLE: mem_req=0. If fml_stb, go to BEAT_H. Exception: a write with sel[3:2]==0 goes to BEAT_L. A write with sel==4'b0000 goes straight to DONE (no memory access).
  - BEAT_H: mem_req=1 with beat-H fields. On mem_ack: latch rd_hi<=mem_rdat when reading. Then go to BEAT_L, unless this is a write with sel[1:0]==0, in which case go to DONE.
  - BEAT_L: mem_req=1 with beat-L fields. On mem_ack: latch rd_lo<=mem_rdat when reading, then go to DONE.
  - DONE: mem_req=0, fml_ack=1 for exactly one cycle, then go to IDLE.
- Reads always issue both beats with mem_be=2'b11, regardless of sel.
- Back-to-back beats: mem_req stays high across the H->L transition. Beat-L fields appear the cycle after the beat-H mem_ack. A mem_ack seen in a given cycle always refers to the beat presented in that cycle.
- fml_do={rd_hi,rd_lo}. It is valid in the DONE cycle and held until the next read's beat-H ack. Writes do not alter fml_do.
- Latency with zero-wait memory (mem_ack in the first req cycle): stb accepted at cycle 0; BEAT_H at cycle 1; BEAT_L at cycle 2; ack at cycle 3.
- mem_ack arriving in IDLE or DONE is ignored.
- A new request is accepted no earlier than the cycle after DONE. Upstream has dropped stb by then. If fml_stb is still high in IDLE, it is treated as a new request.
- Wait states: unbounded. No timeout.

Decomposition:
- Shared package fml16_pkg:
  - state encoding constants IDLE=0, BEAT_H=1, BEAT_L=2, DONE=3;
  - constants HALF_HI=1'b0, HALF_LO=1'b1.
- Single module; no sub-module needed. The beat-field mux is inline.

Test Plan:
1. Read, zero-wait: adr=0x0000100, mem_rdat 0xDEAD then 0xBEEF -> mem_adr 0x0000080 then 0x0000081, mem_be=11 both beats, fml_ack at cycle 3, fml_do=0xDEADBEEF.
2. Write, sel=1111, di=0x12345678, mem_ack delayed 3 cycles per beat -> beat H wdat=0x1234 be=11, beat L wdat=0x5678 be=11, req held through waits, one fml_ack pulse.
3. Write sel=0011 -> only beat L issued (wdat=low half, be=11). Write sel=1100 -> only beat H issued. Write sel=0000 -> no mem_req, fml_ack one cycle after accept.
4. Upstream changes fml_di/fml_adr during BEAT_H wait -> memory beats still carry the captured values.
5. sys_rst_n pulsed low during BEAT_L -> all outputs 0 immediately (asynchronous); no fml_ack; next request after release runs normally.
6. Two back-to-back reads 0xAAAA5555 then 0x0F0FF0F0 -> two separate ack pulses; fml_do updates only on the second read's beat-H ack; a spurious mem_ack in IDLE is ignored.
